ext_bus_responder: RTL and testbench

Single-clock responder for the 6502C external bus, sitting between the CPU's address/data/nRW pins and a variable-latency backing memory port. It decodes a selected address window and answers CPU reads by driving the read data byte and RDY, stretching the read cycle with RDY low until memory returns data. It absorbs CPU writes into a 2-entry posted-write FIFO, because the CPU ignores RDY while writing. It is the bus-side counterpart of the CPU's ready-control and predecode-register path.

---
 rtl/ext_bus_responder_if.sv | 27 ++
 rtl/ext_bus_responder.sv | 133 +++++++++++++
 tb/tb_ext_bus_responder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ext_bus_responder_if.sv
// CPU external bus plus backing-memory port of the 6502C bus responder.
// The responder takes the slave side; the CPU/memory side takes the master side.
interface ext_bus_responder_if;
  logic [15:0] addr;
  logic        nRW;
  logic [7:0]  cpuDataOut;
  logic [7:0]  dataIn;
  logic        RDY;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        ovfErr;
  logic        toErr;

  modport slave (
    input  addr, nRW, cpuDataOut, mem_rdata, mem_ack,
    output dataIn, RDY, mem_req, mem_we, mem_addr, mem_wdata, ovfErr, toErr
  );

  modport master (
    output addr, nRW, cpuDataOut, mem_rdata, mem_ack,
    input  dataIn, RDY, mem_req, mem_we, mem_addr, mem_wdata, ovfErr, toErr
  );
endinterface

// File: rtl/ext_bus_responder.sv
// Answers selected 6502C bus reads from a variable-latency memory (stretching with RDY)
// and posts CPU writes through a 2-entry FIFO, since the CPU ignores RDY on writes.
module ext_bus_responder #(
  parameter logic [15:0] BASE    = 16'h0000,
  parameter logic [15:0] MASK    = 16'hC000,
  parameter int          TIMEOUT = 15
) (
  input  logic               phi2,
  input  logic               rstAll,
  ext_bus_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD, RDONE} state_t;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_entry_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  wr_entry_t   fifo_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q;
  logic [7:0]  tcnt_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wdata_q, data_in_q;
  logic        ovf_q, to_q;
  logic        sel, rd_req, wr_req, fifo_full, pop, push;
  logic        ld_wr, ld_rd, rd_ack, rd_to, mem_req, mem_we;

  assign sel       = (bus.addr & MASK) == (BASE & MASK);
  assign rd_req    = sel & bus.nRW;
  assign wr_req    = sel & ~bus.nRW;
  assign fifo_full = (cnt_q == 2'd2);
  assign pop       = (state_q == WR) & bus.mem_ack;
  // A full FIFO still takes the write if the head drains on the same edge.
  assign push      = wr_req & (~fifo_full | pop);

  always_ff @(posedge phi2) begin
    if (push) fifo_q[wr_ptr_q] <= '{addr: bus.addr, data: bus.cpuDataOut};
  end

  always_ff @(posedge phi2) begin
    if (rstAll) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      if (wr_req & ~push) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    ld_wr   = 1'b0;
    ld_rd   = 1'b0;
    rd_ack  = 1'b0;
    rd_to   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        // Drain posted writes before any read so memory sees program order.
        if (cnt_q != 2'd0) begin
          state_d = WR;
          ld_wr   = 1'b1;
        end else if (rd_req) begin
          state_d = RD;
          ld_rd   = 1'b1;
        end
      end
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_ack) state_d = IDLE;
      end
      RD: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          state_d = RDONE;
          rd_ack  = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          state_d = RDONE;
          rd_to   = 1'b1;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi2) begin
    if (rstAll) begin
      state_q     <= IDLE;
      tcnt_q      <= 8'd0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 8'h00;
      data_in_q   <= 8'h00;
      to_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ld_wr) begin
        mem_addr_q  <= fifo_q[rd_ptr_q].addr;
        mem_wdata_q <= fifo_q[rd_ptr_q].data;
      end
      // Latch the read address so a bus change mid-wait cannot alter the request.
      if (ld_rd) begin
        mem_addr_q <= bus.addr;
        tcnt_q     <= 8'd0;
      end else if (state_q == RD) begin
        tcnt_q <= tcnt_q + 8'd1;
      end
      if (rd_ack) data_in_q <= bus.mem_rdata;
      if (rd_to) begin
        data_in_q <= 8'hFF;
        to_q      <= 1'b1;
      end
    end
  end

  assign bus.dataIn    = data_in_q;
  assign bus.RDY       = ~rd_req | (state_q == RDONE);
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ovfErr    = ovf_q;
  assign bus.toErr     = to_q;
endmodule

// File: tb/tb_ext_bus_responder.sv
// Directed bench for ext_bus_responder: memory transactions and read data are
// predicted into scoreboard queues and checked as the DUT produces them.
module tb_ext_bus_responder;
  logic phi2;
  logic rstAll;
  ext_bus_responder_if bus ();

  ext_bus_responder dut (
    .phi2   (phi2),
    .rstAll (rstAll),
    .bus    (bus)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
  } mem_t;

  mem_t       exp_mem [$];
  logic [7:0] exp_rd  [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called in a cycle where the bench drives mem_ack: the active transaction
  // must be the oldest one predicted.
  task automatic mem_chk();
    mem_t e;
    if (bus.mem_req) begin
      chk("mem_pending", 32'(exp_mem.size() > 0), 32'd1);
      if (exp_mem.size() > 0) begin
        e = exp_mem.pop_front();
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
        chk("mem_addr", {16'd0, bus.mem_addr}, {16'd0, e.addr});
        if (e.we) chk("mem_wdata", {24'd0, bus.mem_wdata}, {24'd0, e.data});
      end
    end
  endtask

  task automatic step();
    @(posedge phi2);
    #1;
  endtask

  task automatic idle(input int n, input logic [63:0] ack_mask);
    bus.addr = 16'hC000;
    bus.nRW  = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.mem_ack = ack_mask[i];
      @(negedge phi2);
      if (bus.mem_ack) mem_chk();
      step();
      bus.mem_ack = 1'b0;
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic ack,
                           input bit accepted);
    bus.addr       = a;
    bus.nRW        = 1'b0;
    bus.cpuDataOut = d;
    bus.mem_ack    = ack;
    if (accepted) exp_mem.push_back('{1'b1, a, d});
    @(negedge phi2);
    if (ack) mem_chk();
    chk("wr_rdy", {31'd0, bus.RDY}, 32'd1);
    step();
    bus.mem_ack = 1'b0;
    bus.nRW     = 1'b1;
    bus.addr    = 16'hC000;
  endtask

  // Holds a selected read until RDY rises; ack_mask bit i drives mem_ack in cycle i.
  task automatic cpu_read(input logic [15:0] a, input logic [63:0] ack_mask,
                          input logic [7:0] rd, input int exp_lows, input string tag);
    int lows;
    bit done;
    lows = 0;
    done = 0;
    bus.addr      = a;
    bus.nRW       = 1'b1;
    bus.mem_rdata = rd;
    for (int i = 0; i < 64 && !done; i++) begin
      bus.mem_ack = ack_mask[i];
      @(negedge phi2);
      if (bus.mem_ack) mem_chk();
      if (bus.RDY) begin
        done = 1;
        chk({tag, "_rd_pending"}, 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) chk({tag, "_dataIn"}, {24'd0, bus.dataIn}, {24'd0, exp_rd.pop_front()});
      end else begin
        lows++;
      end
      step();
      bus.mem_ack = 1'b0;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_rdy_low"}, lows, exp_lows);
    bus.addr = 16'hC000;
  endtask

  task automatic apply_reset();
    rstAll = 1'b1;
    step();
    rstAll = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rstAll         = 1'b1;
    bus.addr       = 16'hC000;
    bus.nRW        = 1'b1;
    bus.cpuDataOut = 8'h00;
    bus.mem_rdata  = 8'h00;
    bus.mem_ack    = 1'b0;
    step();
    apply_reset();

    // reset state
    @(negedge phi2);
    chk("rst_dataIn", {24'd0, bus.dataIn}, 32'h00);
    chk("rst_rdy", {31'd0, bus.RDY}, 32'd1);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, bus.mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'h0);
    chk("rst_ovf", {31'd0, bus.ovfErr}, 32'd0);
    chk("rst_to", {31'd0, bus.toErr}, 32'd0);
    step();

    // basic read: ack in cycle 3 -> 4 stall cycles
    exp_mem.push_back('{1'b0, 16'h0123, 8'h00});
    exp_rd.push_back(8'hA5);
    cpu_read(16'h0123, 64'h8, 8'hA5, 4, "rd1");

    // back-to-back read sees the mandatory IDLE cycle
    exp_mem.push_back('{1'b0, 16'h0124, 8'h00});
    exp_rd.push_back(8'h3C);
    cpu_read(16'h0124, 64'h2, 8'h3C, 2, "rd2");

    // two posted writes drain in order before the read
    cpu_write(16'h0010, 8'h11, 1'b0, 1);
    cpu_write(16'h0011, 8'h22, 1'b0, 1);
    exp_mem.push_back('{1'b0, 16'h0010, 8'h00});
    exp_rd.push_back(8'h5A);
    cpu_read(16'h0010, 64'h2A, 8'h5A, 6, "rd_after_wr");

    // third write into a full FIFO without a pop is dropped
    cpu_write(16'h0020, 8'h01, 1'b0, 1);
    cpu_write(16'h0021, 8'h02, 1'b0, 1);
    cpu_write(16'h0022, 8'h03, 1'b0, 0);
    idle(4, 64'h5);
    @(negedge phi2);
    chk("ovf_set", {31'd0, bus.ovfErr}, 32'd1);
    chk("ovf_drained", exp_mem.size(), 0);
    step();

    apply_reset();
    @(negedge phi2);
    chk("ovf_cleared", {31'd0, bus.ovfErr}, 32'd0);
    step();

    // pop on the third cycle makes room for the third write
    cpu_write(16'h0030, 8'h0A, 1'b0, 1);
    cpu_write(16'h0031, 8'h0B, 1'b0, 1);
    cpu_write(16'h0032, 8'h0C, 1'b1, 1);
    idle(5, 64'hA);
    @(negedge phi2);
    chk("no_ovf", {31'd0, bus.ovfErr}, 32'd0);
    chk("all_drained", exp_mem.size(), 0);
    step();

    // timeout with no ack
    exp_rd.push_back(8'hFF);
    cpu_read(16'h0200, 64'h0, 8'h99, 16, "rd_to");
    @(negedge phi2);
    chk("to_set", {31'd0, bus.toErr}, 32'd1);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h42;
    @(negedge phi2);
    chk("late_ack_no_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    bus.mem_ack = 1'b0;
    @(negedge phi2);
    chk("late_ack_dataIn", {24'd0, bus.dataIn}, 32'hFF);
    chk("late_ack_to", {31'd0, bus.toErr}, 32'd1);
    step();

    // unselected read
    bus.addr = 16'hC000;
    bus.nRW  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge phi2);
      chk("unsel_rdy", {31'd0, bus.RDY}, 32'd1);
      chk("unsel_req", {31'd0, bus.mem_req}, 32'd0);
      step();
    end

    // reset in the middle of RD
    bus.addr = 16'h0300;
    bus.nRW  = 1'b1;
    @(negedge phi2);
    step();
    @(negedge phi2);
    chk("mid_rd_req", {31'd0, bus.mem_req}, 32'd1);
    chk("mid_rd_rdy", {31'd0, bus.RDY}, 32'd0);
    step();
    rstAll = 1'b1;
    step();
    rstAll      = 1'b0;
    bus.addr    = 16'hC000;
    bus.mem_ack = 1'b1;
    @(negedge phi2);
    chk("post_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("post_rst_rdy", {31'd0, bus.RDY}, 32'd1);
    chk("post_rst_to", {31'd0, bus.toErr}, 32'd0);
    chk("post_rst_ovf", {31'd0, bus.ovfErr}, 32'd0);
    chk("post_rst_dataIn", {24'd0, bus.dataIn}, 32'h00);
    chk("post_rst_addr", {16'd0, bus.mem_addr}, 32'h0);
    step();
    bus.mem_ack = 1'b0;

    // responder is back in IDLE: a fresh read behaves normally
    exp_mem.push_back('{1'b0, 16'h0040, 8'h00});
    exp_rd.push_back(8'h77);
    cpu_read(16'h0040, 64'h2, 8'h77, 2, "rd_post_rst");

    chk("sb_mem_empty", exp_mem.size(), 0);
    chk("sb_rd_empty", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
